// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM states, bus size
// codes, load/store byte-select values and a size-decode helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_t;

    localparam logic [1:0] BUS_SIZE_BYTE = 2'd0;
    localparam logic [1:0] BUS_SIZE_HALF = 2'd1;
    localparam logic [1:0] BUS_SIZE_WORD = 2'd2;

    localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
    localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    // Unsupported selects decode to word; they never reach the bus anyway.
    function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
        case (sel)
            MEM_SEL_BYTE: sel_to_size = BUS_SIZE_BYTE;
            MEM_SEL_HALF: sel_to_size = BUS_SIZE_HALF;
            default:      sel_to_size = BUS_SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_store_align.sv
// Store lane steering: byte strobes, write-data replication and
// misalignment detection for a load/store request.
module mem_store_align
    import mem_bus_arbiter_pkg::*;
(
    input  logic        wr,
    input  logic [3:0]  sel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_out,
    output logic [1:0]  size,
    output logic        misaligned
);

    // Replicate narrow stores across all lanes and place strobes on the addressed bytes
    always_comb begin
        wstrb      = WSTRB_NONE;
        wdata_out  = wdata_in;
        size       = sel_to_size(sel);
        misaligned = 1'b0;
        case (sel)
            MEM_SEL_BYTE: wdata_out = {4{wdata_in[7:0]}};
            MEM_SEL_HALF: begin
                wdata_out  = {2{wdata_in[15:0]}};
                misaligned = addr_lo[0];
            end
            MEM_SEL_WORD: misaligned = (addr_lo != 2'b00);
            default:      misaligned = 1'b1;
        endcase
        if (wr && !misaligned) begin
            wstrb = sel << addr_lo;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction fetch and load/store ports onto one SRAM-like bus,
// one transaction at a time, with alternating priority on ties.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_sel,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        data_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    arb_state_t  state_q, state_d;
    logic        last_data_q, last_data_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;

    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata;
    logic [1:0]  align_size;
    logic        align_misaligned;

    mem_store_align u_align (
        .wr         (data_wr),
        .sel        (data_sel),
        .addr_lo    (data_addr[1:0]),
        .wdata_in   (data_wdata),
        .wstrb      (align_wstrb),
        .wdata_out  (align_wdata),
        .size       (align_size),
        .misaligned (align_misaligned)
    );

    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);

    // Next-state, grant latching and handshake pulses; everything forced low while in reset
    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        data_err     = 1'b0;
        bus_req      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_req && (!inst_req || !last_data_q)) begin
                    owner_d     = OWNER_DATA;
                    last_data_d = 1'b1;
                    if (align_misaligned) begin
                        data_addr_ok = 1'b1;
                        state_d      = ST_ERR;
                    end else begin
                        wr_d    = data_wr;
                        size_d  = align_size;
                        addr_d  = data_addr;
                        wstrb_d = align_wstrb;
                        wdata_d = align_wdata;
                        state_d = ST_REQ;
                    end
                end else if (inst_req) begin
                    owner_d     = OWNER_INST;
                    last_data_d = 1'b0;
                    wr_d        = 1'b0;
                    size_d      = BUS_SIZE_WORD;
                    addr_d      = inst_addr;
                    wstrb_d     = WSTRB_NONE;
                    wdata_d     = 32'h0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    data_addr_ok = (owner_q == OWNER_DATA);
                    inst_addr_ok = (owner_q == OWNER_INST);
                    if (bus_data_ok) begin
                        data_data_ok = (owner_q == OWNER_DATA);
                        inst_data_ok = (owner_q == OWNER_INST);
                        data_rdata   = (owner_q == OWNER_DATA) ? bus_rdata : 32'h0;
                        inst_rdata   = (owner_q == OWNER_INST) ? bus_rdata : 32'h0;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    data_data_ok = (owner_q == OWNER_DATA);
                    inst_data_ok = (owner_q == OWNER_INST);
                    data_rdata   = (owner_q == OWNER_DATA) ? bus_rdata : 32'h0;
                    inst_rdata   = (owner_q == OWNER_INST) ? bus_rdata : 32'h0;
                    state_d      = ST_IDLE;
                end
            end
            ST_ERR: begin
                data_data_ok = 1'b1;
                data_err     = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata   = 32'h0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = 32'h0;
            data_err     = 1'b0;
            bus_req      = 1'b0;
        end
    end

    // State and latched-request registers; reset leaves instruction as last grantee
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_data_q <= 1'b0;
            owner_q     <= OWNER_INST;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= 32'h0;
            wstrb_q     <= 4'h0;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, reset
// corner sequences and randomized requests against a transaction-level model.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_sel;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok, data_err;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    int checks;
    int failures;
    bit model_last_data;

    typedef struct {
        bit          ir;
        bit          dr;
        bit          wr;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] iaddr;
        logic [31:0] rdata;
        int          mode;
        bit          first_data;
        bit          mis;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] ewdata;
    } vec_t;

    vec_t vecs[8];

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_sel     (data_sel),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .data_err     (data_err),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- transaction-level reference model ----
    function automatic int selBytes(input logic [3:0] sel);
        if (sel == 4'b0001) return 1;
        if (sel == 4'b0011) return 2;
        if (sel == 4'b1111) return 4;
        return 0;
    endfunction

    function automatic bit modelMis(input logic [3:0] sel, input logic [31:0] addr);
        int n;
        n = selBytes(sel);
        if (n == 0) return 1'b1;
        return (int'(addr[1:0]) % n) != 0;
    endfunction

    function automatic logic [3:0] modelWstrb(input bit wr, input logic [3:0] sel, input logic [31:0] addr);
        logic [3:0] s;
        int a, n;
        s = 4'b0000;
        a = int'(addr[1:0]);
        n = selBytes(sel);
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= a && i < a + n) s[i] = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [3:0] sel, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        r = 32'h0;
        n = selBytes(sel);
        if (n == 0) n = 4;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        return r;
    endfunction

    function automatic logic [1:0] modelSize(input logic [3:0] sel);
        int n;
        n = selBytes(sel);
        if (n == 1) return 2'd0;
        if (n == 2) return 2'd1;
        return 2'd2;
    endfunction

    function automatic vec_t mk(input bit ir, input bit dr, input bit wr, input logic [3:0] sel,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] iaddr, input logic [31:0] rdata, input int mode,
                                input bit first_data, input bit mis, input logic [1:0] size,
                                input logic [3:0] wstrb, input logic [31:0] ewdata);
        vec_t v;
        v.ir = ir; v.dr = dr; v.wr = wr; v.sel = sel; v.addr = addr; v.wdata = wdata;
        v.iaddr = iaddr; v.rdata = rdata; v.mode = mode; v.first_data = first_data;
        v.mis = mis; v.size = size; v.wstrb = wstrb; v.ewdata = ewdata;
        return v;
    endfunction

    task automatic checkBus(input logic [31:0] e_addr, input bit e_wr, input logic [1:0] e_size,
                            input logic [3:0] e_wstrb, input logic [31:0] e_wdata);
        checkOutput("req_bus_req", bus_req, 1);
        checkOutput("req_bus_addr", bus_addr, e_addr);
        checkOutput("req_bus_wr", bus_wr, e_wr);
        checkOutput("req_bus_size", bus_size, e_size);
        checkOutput("req_bus_wstrb", bus_wstrb, e_wstrb);
        if (e_wr) checkOutput("req_bus_wdata", bus_wdata, e_wdata);
    endtask

    // Serves one granted transaction, starting in the IDLE cycle where the requests are visible
    task automatic serveTxn(input bit own_data, input bit e_mis, input logic [31:0] e_addr,
                            input bit e_wr, input logic [1:0] e_size, input logic [3:0] e_wstrb,
                            input logic [31:0] e_wdata, input logic [31:0] rdata, input int mode);
        int lat;
        bit same;
        logic own_aok, oth_aok, own_dok, oth_dok;
        logic [31:0] own_rd;
        bus_data_ok = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        #3;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_bus_req", bus_req, 0);
        checkOutput("idle_no_data_ok", {inst_data_ok, data_data_ok}, 0);
        if (own_data && e_mis) begin
            checkOutput("err_grant_addr_ok", data_addr_ok, 1);
            checkOutput("err_grant_inst_addr_ok", inst_addr_ok, 0);
            tick();
            data_req = 1'b0;
            bus_data_ok = 1'b0;
            #3;
            checkOutput("err_data_ok", data_data_ok, 1);
            checkOutput("err_flag", data_err, 1);
            checkOutput("err_rdata", data_rdata, 0);
            checkOutput("err_bus_req", bus_req, 0);
            checkOutput("err_inst_data_ok", inst_data_ok, 0);
            tick();
            return;
        end
        checkOutput("grant_no_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        tick();
        bus_data_ok = 1'b0;
        lat = (mode == 1) ? 0 : int'($urandom_range(0, 2));
        for (int i = 0; i < lat; i++) begin
            bus_data_ok = 1'($urandom_range(0, 1));
            #3;
            checkBus(e_addr, e_wr, e_size, e_wstrb, e_wdata);
            checkOutput("req_stall_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
            checkOutput("req_stall_data_ok", {inst_data_ok, data_data_ok}, 0);
            tick();
        end
        same = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        bus_addr_ok = 1'b1;
        bus_data_ok = same;
        bus_rdata = rdata;
        #3;
        checkBus(e_addr, e_wr, e_size, e_wstrb, e_wdata);
        own_aok = own_data ? data_addr_ok : inst_addr_ok;
        oth_aok = own_data ? inst_addr_ok : data_addr_ok;
        own_dok = own_data ? data_data_ok : inst_data_ok;
        oth_dok = own_data ? inst_data_ok : data_data_ok;
        own_rd  = own_data ? data_rdata : inst_rdata;
        checkOutput("addr_ok_owner", own_aok, 1);
        checkOutput("addr_ok_other", oth_aok, 0);
        checkOutput("addr_ok_data_err", data_err, 0);
        if (same) begin
            checkOutput("same_data_ok_owner", own_dok, 1);
            checkOutput("same_rdata", own_rd, rdata);
        end else begin
            checkOutput("split_no_early_data_ok", own_dok, 0);
        end
        checkOutput("data_ok_other", oth_dok, 0);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (own_data) data_req = 1'b0; else inst_req = 1'b0;
        if (!same) begin
            lat = int'($urandom_range(0, 2));
            for (int i = 0; i < lat; i++) begin
                #3;
                checkOutput("wait_bus_req", bus_req, 0);
                checkOutput("wait_busy", busy, 1);
                checkOutput("wait_no_data_ok", {inst_data_ok, data_data_ok}, 0);
                tick();
            end
            bus_data_ok = 1'b1;
            bus_rdata = rdata;
            #3;
            own_dok = own_data ? data_data_ok : inst_data_ok;
            oth_dok = own_data ? inst_data_ok : data_data_ok;
            own_rd  = own_data ? data_rdata : inst_rdata;
            checkOutput("wait_data_ok_owner", own_dok, 1);
            checkOutput("wait_data_ok_other", oth_dok, 0);
            checkOutput("wait_rdata", own_rd, rdata);
            checkOutput("wait_done_bus_req", bus_req, 0);
            checkOutput("wait_done_data_err", data_err, 0);
            tick();
            bus_data_ok = 1'b0;
        end
    endtask

    // Drives one request set and serves every transaction it produces in model order
    task automatic applyStimulus(input vec_t v);
        tick();
        inst_req   = v.ir;
        inst_addr  = v.iaddr;
        data_req   = v.dr;
        data_wr    = v.wr;
        data_sel   = v.sel;
        data_addr  = v.addr;
        data_wdata = v.wdata;
        if (v.ir && v.dr) begin
            if (v.first_data) begin
                serveTxn(1'b1, v.mis, v.addr, v.wr, v.size, v.wstrb, v.ewdata, v.rdata, v.mode);
                serveTxn(1'b0, 1'b0, v.iaddr, 1'b0, 2'd2, 4'b0000, 32'h0, v.rdata, v.mode);
            end else begin
                serveTxn(1'b0, 1'b0, v.iaddr, 1'b0, 2'd2, 4'b0000, 32'h0, v.rdata, v.mode);
                serveTxn(1'b1, v.mis, v.addr, v.wr, v.size, v.wstrb, v.ewdata, v.rdata, v.mode);
            end
            model_last_data = !v.first_data;
        end else if (v.dr) begin
            serveTxn(1'b1, v.mis, v.addr, v.wr, v.size, v.wstrb, v.ewdata, v.rdata, v.mode);
            model_last_data = 1'b1;
        end else begin
            serveTxn(1'b0, 1'b0, v.iaddr, 1'b0, 2'd2, 4'b0000, 32'h0, v.rdata, v.mode);
            model_last_data = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        int r;
        checks = 0;
        failures = 0;
        model_last_data = 1'b0;
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_sel = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

        vecs[0] = mk(1, 1, 1, 4'b0001, 32'h80000003, 32'h000000A5, 32'hBFC00000, 32'h24020001, 0,
                     1, 0, 2'd0, 4'b1000, 32'hA5A5A5A5);
        vecs[1] = mk(0, 1, 0, 4'b0011, 32'h80000001, 32'h0, 32'h0, 32'h0, 0,
                     1, 1, 2'd1, 4'b0000, 32'h0);
        vecs[2] = mk(0, 1, 1, 4'b0011, 32'h80000002, 32'h1234BEEF, 32'h0, 32'hCAFE0001, 0,
                     1, 0, 2'd1, 4'b1100, 32'hBEEFBEEF);
        vecs[3] = mk(1, 1, 0, 4'b1111, 32'h80001000, 32'h0, 32'hBFC00004, 32'h12345678, 1,
                     0, 0, 2'd2, 4'b0000, 32'h0);
        vecs[4] = mk(0, 1, 1, 4'b0101, 32'h80000000, 32'h11223344, 32'h0, 32'h0, 0,
                     1, 1, 2'd2, 4'b0000, 32'h0);
        vecs[5] = mk(0, 1, 1, 4'b1111, 32'h80000004, 32'hDEADBEEF, 32'h0, 32'h0BADF00D, 2,
                     1, 0, 2'd2, 4'b1111, 32'hDEADBEEF);
        vecs[6] = mk(1, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h00000010, 32'h13579BDF, 0,
                     0, 0, 2'd2, 4'b0000, 32'h0);
        vecs[7] = mk(1, 1, 1, 4'b1111, 32'h80000002, 32'h00000055, 32'hBFC00008, 32'h2468ACE0, 0,
                     1, 1, 2'd2, 4'b0000, 32'h0);

        // reset state, including a misaligned request that must not be acknowledged under reset
        tick();
        data_req = 1'b1; data_sel = 4'b0011; data_addr = 32'h80000001;
        tick();
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_bus_req", bus_req, 0);
        checkOutput("rst_bus_addr", bus_addr, 0);
        checkOutput("rst_bus_wstrb", bus_wstrb, 0);
        checkOutput("rst_bus_size", bus_size, 0);
        checkOutput("rst_data_addr_ok", data_addr_ok, 0);
        checkOutput("rst_data_err", data_err, 0);
        checkOutput("rst_inst_addr_ok", inst_addr_ok, 0);
        data_req = 1'b0; data_sel = 4'h0; data_addr = 32'h0;
        tick();
        rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset while waiting for read data");
        tick();
        data_req = 1'b1; data_wr = 1'b0; data_sel = 4'b1111; data_addr = 32'h80002000;
        tick();
        bus_addr_ok = 1'b1;
        #3;
        checkOutput("mid_rst_addr_ok", data_addr_ok, 1);
        tick();
        bus_addr_ok = 1'b0;
        data_req = 1'b0;
        #3;
        checkOutput("mid_rst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy_async", busy, 0);
        checkOutput("mid_rst_bus_addr_async", bus_addr, 0);
        checkOutput("mid_rst_bus_req_async", bus_req, 0);
        tick();
        tick();
        rst = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata = 32'hFEEDFACE;
        #3;
        checkOutput("mid_rst_no_data_ok", {inst_data_ok, data_data_ok}, 0);
        checkOutput("mid_rst_data_rdata", data_rdata, 0);
        tick();
        bus_data_ok = 1'b0;
        model_last_data = 1'b0;
        applyStimulus(mk(1, 1, 0, 4'b1111, 32'h80003000, 32'h0, 32'hBFC00010, 32'h0F0F0F0F, 2,
                         1, 0, 2'd2, 4'b0000, 32'h0));

        $display("[TB] randomized requests against model");
        for (int n = 0; n < 40; n++) begin
            v.ir = 1'($urandom_range(0, 1));
            v.dr = 1'($urandom_range(0, 1));
            if (!v.ir && !v.dr) v.dr = 1'b1;
            v.wr = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            if (r < 2) v.sel = 4'b0001;
            else if (r < 4) v.sel = 4'b0011;
            else if (r < 6) v.sel = 4'b1111;
            else v.sel = 4'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.iaddr = $urandom;
            v.rdata = $urandom;
            v.mode  = 0;
            v.first_data = (v.ir && v.dr) ? !model_last_data : v.dr;
            v.mis    = v.dr ? modelMis(v.sel, v.addr) : 1'b0;
            v.size   = modelSize(v.sel);
            v.wstrb  = modelWstrb(v.wr, v.sel, v.addr);
            v.ewdata = modelWdata(v.sel, v.wdata);
            applyStimulus(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports (name dir width meaning):
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 inst_req in 1 / inst_addr in 32 / inst_addr_ok out 1 / inst_data_ok out 1 / inst_rdata out 32  fetch-side read port.
REQ-005 data_req in 1 / data_wr in 1 / data_sel in 4 (0001 byte, 0011 half, 1111 word) / data_addr in 32 / data_wdata in 32  load/store request.
REQ-006 data_addr_ok out 1 / data_data_ok out 1 / data_rdata out 32 / data_err out 1  load/store response.
REQ-007 bus_req out 1 / bus_wr out 1 / bus_size out 2 / bus_addr out 32 / bus_wstrb out 4 / bus_wdata out 32  shared SRAM-like bus request.
REQ-008 bus_addr_ok in 1 / bus_data_ok in 1 / bus_rdata in 32  shared bus response; busy out 1 = FSM not IDLE.

Function
REQ-009 FSM states SHALL be IDLE, REQ, WAIT, ERR; one transaction outstanding at most.
REQ-010 IDLE: grant when any req; both requesting -> requester not granted last wins; first tie after reset -> data.
REQ-011 On grant, owner, wr, size, addr, wstrb, wdata SHALL be latched; bus outputs driven only from latched values.
REQ-012 Requesters SHALL hold req and attributes stable until their addr_ok; the arbiter ignores changes after grant.
REQ-013 REQ: bus_req=1; bus_addr_ok=1 -> owner's addr_ok pulses that cycle (combinational), go WAIT.
REQ-014 REQ with bus_addr_ok and bus_data_ok both 1 in the same cycle SHALL complete directly to IDLE, both pulses to owner.
REQ-015 WAIT: bus_req=0; bus_data_ok=1 -> owner's data_ok pulses one cycle, rdata=bus_rdata (raw word, no lane extraction), go IDLE.
REQ-016 bus_data_ok in IDLE or REQ-without-addr_ok SHALL be ignored (no data_ok pulse).
REQ-017 bus_size: 0001->0, 0011->1, 1111->2; inst reads SHALL use size 2, wstrb 0000.
REQ-018 Store wstrb = data_sel << addr[1:0]; wdata byte replicated x4, half replicated x2, word unchanged; loads wstrb 0000.
REQ-019 Misaligned data access (half with addr[0]=1, word with addr[1:0]!=0, or sel not in {0001,0011,1111}) SHALL NOT reach the bus: data_addr_ok pulses at grant cycle, go ERR, next cycle data_data_ok=1, data_err=1, data_rdata=0, go IDLE.
REQ-020 data_err SHALL be 0 except in the ERR completion cycle; inst_* outputs never assert for a data transaction and vice versa.
REQ-021 Earliest bus_req is the cycle after grant; minimum round trip IDLE->REQ->IDLE is 2 cycles.

Reset
REQ-022 rst SHALL force IDLE, last-grant=inst (so data wins next tie), all outputs 0, immediately and asynchronously.
REQ-023 Reset mid-transaction SHALL abandon it; no data_ok pulse for it after release.

Structure
REQ-024 FSM state encoding, bus_size codes and mem_sel values SHALL live in the shared include package alongside the bus/opcode defines.
REQ-025 Store lane steering (wstrb, wdata replication, misalignment detect) SHALL be one combinational sub-module, mem_store_align.

Verification
REQ-026 Data store sel=0001 addr=0x80000003 wdata=0x000000A5 -> bus_wstrb=1000, bus_wdata=0xA5A5A5A5, bus_size=0.
REQ-027 inst_req and data_req together after reset -> data granted first, then inst; inst_rdata=bus_rdata=0x24020001 on inst_data_ok.
REQ-028 Load sel=0011 addr=0x80000001 -> no bus_req, data_addr_ok then data_data_ok+data_err next cycle, data_rdata=0.
REQ-029 Bus returns bus_addr_ok and bus_data_ok same cycle for load 0x80001000 rdata 0x12345678 -> single-cycle completion, data_rdata=0x12345678, busy drops next cycle.
REQ-030 rst asserted in WAIT then bus_data_ok arrives -> no data_ok pulse, all outputs 0, next request granted normally.
